// File: rtl/mod_147_rx_sync_monitor.sv
// rtl/mod_147_rx_sync_monitor.sv - PCS receive code-group sync monitor
//
// Qualifies received 5B code-groups and tracks code-group synchronisation
// for the link monitor: acquisition run, error window and a saturating
// invalid-symbol counter. All outputs come straight from registers.
//
// Optional feature macro: RX_STALL_WATCHDOG_EN (drops sync after
// STALL_CYCLES clocks without a symbol strobe while not in SYNC_LOST).
//
// Ports:
//   clk            block clock (symbol rate <= clk rate)
//   reset_n        synchronous reset, active-low
//   link_control   0 = ENABLE, 1 = DISABLE (acts as reset, keeps sym_err_count)
//   rx_sym_valid   one-clock strobe qualifying rx_sym
//   rx_sym         received 5B code-group
//   pcs_status     0 = OK, 1 = NOT_OK
//   loc_rcv_status 1 = local receiver OK
//   sync_state     0 LOST, 1 ACQ, 2 OK, 3 ERR
//   sym_err_count  saturating count of invalid code-groups
module mod_147_rx_sync_monitor #(
  parameter int ACQ_COUNT    = 64,
  parameter int LOSS_COUNT   = 8,
  parameter int WINDOW       = 32,
  parameter int STALL_CYCLES = 1024,
  parameter int ERR_CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 link_control,
  input  logic                 rx_sym_valid,
  input  logic [4:0]           rx_sym,
  output logic                 pcs_status,
  output logic                 loc_rcv_status,
  output logic [1:0]           sync_state,
  output logic [ERR_CNT_W-1:0] sym_err_count
);

  localparam int CNT_MAX = (ACQ_COUNT > WINDOW) ? ACQ_COUNT : WINDOW;
  // One spare count of headroom so win_cnt + 1 never wraps, even for WINDOW = 1.
  localparam int CNT_W = $clog2(CNT_MAX + 2);

  localparam logic [CNT_W-1:0]     ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]     ACQ_C  = CNT_W'(ACQ_COUNT);
  localparam logic [CNT_W-1:0]     LOSS_C = CNT_W'(LOSS_COUNT);
  localparam logic [CNT_W-1:0]     WIN_C  = CNT_W'(WINDOW);
  localparam logic [ERR_CNT_W-1:0] ERR_ONE = ERR_CNT_W'(1);

  typedef enum logic [1:0] {
    SYNC_LOST = 2'd0,
    SYNC_ACQ  = 2'd1,
    SYNC_OK   = 2'd2,
    SYNC_ERR  = 2'd3
  } sync_t;

  sync_t                state_q, state_d;
  logic [CNT_W-1:0]     good_q, good_d;
  logic [CNT_W-1:0]     err_q, err_d, err_next;
  logic [CNT_W-1:0]     win_q, win_d, win_next;
  logic [ERR_CNT_W-1:0] sym_err_q, sym_err_d;
  logic                 sym_ok;
  logic                 stall_hit;

  // 16 data codes plus I, J, K, T, R are legal; everything else is invalid.
  always_comb begin
    case (rx_sym)
      5'b11110, 5'b01001, 5'b10100, 5'b10101,
      5'b01010, 5'b01011, 5'b01110, 5'b01111,
      5'b10010, 5'b10011, 5'b10110, 5'b10111,
      5'b11010, 5'b11011, 5'b11100, 5'b11101,
      5'b11111, 5'b11000, 5'b10001, 5'b01101,
      5'b00111: sym_ok = 1'b1;
      default:  sym_ok = 1'b0;
    endcase
  end

`ifdef RX_STALL_WATCHDOG_EN
  localparam int STALL_W = $clog2(STALL_CYCLES + 1);
  localparam logic [STALL_W-1:0] STALL_ONE  = STALL_W'(1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_CYCLES - 1);

  logic [STALL_W-1:0] stall_q, stall_d;

  // Fires on the idle clock that would make the count reach STALL_CYCLES;
  // a strobe on that same clock clears the counter instead.
  always_comb begin
    stall_d   = stall_q;
    stall_hit = 1'b0;
    if (rx_sym_valid || state_q == SYNC_LOST) begin
      stall_d = '0;
    end else if (stall_q == STALL_LAST) begin
      stall_d   = '0;
      stall_hit = 1'b1;
    end else begin
      stall_d = stall_q + STALL_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || link_control) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end
`else
  // STALL_CYCLES stays in the parameter list so both builds share one interface.
  logic unused_stall_cfg;
  assign unused_stall_cfg = ^STALL_CYCLES;
  assign stall_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    good_d    = good_q;
    err_d     = err_q;
    win_d     = win_q;
    sym_err_d = sym_err_q;
    win_next  = win_q + ONE;
    err_next  = sym_ok ? err_q : err_q + ONE;

    if (rx_sym_valid) begin
      if (!sym_ok && sym_err_q != '1) begin
        sym_err_d = sym_err_q + ERR_ONE;
      end
      case (state_q)
        SYNC_LOST: begin
          if (sym_ok) begin
            if (ACQ_COUNT == 1) begin
              state_d = SYNC_OK;
              good_d  = '0;
            end else begin
              state_d = SYNC_ACQ;
              good_d  = ONE;
            end
          end
        end
        SYNC_ACQ: begin
          if (!sym_ok) begin
            state_d = SYNC_LOST;
            good_d  = '0;
          end else if (good_q + ONE >= ACQ_C) begin
            state_d = SYNC_OK;
            good_d  = '0;
          end else begin
            good_d = good_q + ONE;
          end
        end
        SYNC_OK: begin
          if (!sym_ok) begin
            if (LOSS_COUNT == 1) begin
              state_d = SYNC_LOST;
            end else begin
              state_d = SYNC_ERR;
              err_d   = ONE;
              win_d   = ONE;
            end
          end
        end
        SYNC_ERR: begin
          // Loss is tested first so it wins when the window closes on the same symbol.
          if (err_next >= LOSS_C) begin
            state_d = SYNC_LOST;
            err_d   = '0;
            win_d   = '0;
          end else if (win_next >= WIN_C) begin
            state_d = SYNC_OK;
            err_d   = '0;
            win_d   = '0;
          end else begin
            err_d = err_next;
            win_d = win_next;
          end
        end
        default: state_d = SYNC_LOST;
      endcase
    end else if (stall_hit) begin
      state_d = SYNC_LOST;
      good_d  = '0;
      err_d   = '0;
      win_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= SYNC_LOST;
      good_q    <= '0;
      err_q     <= '0;
      win_q     <= '0;
      sym_err_q <= '0;
    end else if (link_control) begin
      // DISABLE clears sync tracking but keeps the error tally.
      state_q <= SYNC_LOST;
      good_q  <= '0;
      err_q   <= '0;
      win_q   <= '0;
    end else begin
      state_q   <= state_d;
      good_q    <= good_d;
      err_q     <= err_d;
      win_q     <= win_d;
      sym_err_q <= sym_err_d;
    end
  end

  // Status is a decode of the registered state: OK and ERR both mean "in sync".
  assign sync_state     = state_q;
  assign loc_rcv_status = state_q[1];
  assign pcs_status     = ~state_q[1];
  assign sym_err_count  = sym_err_q;

endmodule

// File: tb/tb_mod_147_rx_sync_monitor.sv
// tb/tb_mod_147_rx_sync_monitor.sv - scoreboard bench for mod_147_rx_sync_monitor
module tb_mod_147_rx_sync_monitor;

  localparam int ACQ   = 64;
  localparam int LOSS  = 8;
  localparam int WIN   = 32;
  localparam int STALL = 1024;
  localparam int EW    = 5;
  localparam int ERR_SAT = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          link_control;
  logic          rx_sym_valid;
  logic [4:0]    rx_sym;
  logic          pcs_status;
  logic          loc_rcv_status;
  logic [1:0]    sync_state;
  logic [EW-1:0] sym_err_count;

  always #5 clk = ~clk;

  mod_147_rx_sync_monitor #(
    .ACQ_COUNT(ACQ),
    .LOSS_COUNT(LOSS),
    .WINDOW(WIN),
    .STALL_CYCLES(STALL),
    .ERR_CNT_W(EW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .link_control(link_control),
    .rx_sym_valid(rx_sym_valid),
    .rx_sym(rx_sym),
    .pcs_status(pcs_status),
    .loc_rcv_status(loc_rcv_status),
    .sync_state(sync_state),
    .sym_err_count(sym_err_count)
  );

  typedef struct {
    int state;
    int errs;
    int phase;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   phase  = 0;

  logic [4:0] valid_codes [21] = '{
    5'b11110, 5'b01001, 5'b10100, 5'b10101, 5'b01010, 5'b01011, 5'b01110,
    5'b01111, 5'b10010, 5'b10011, 5'b10110, 5'b10111, 5'b11010, 5'b11011,
    5'b11100, 5'b11101, 5'b11111, 5'b11000, 5'b10001, 5'b01101, 5'b00111};
  logic [4:0] invalid_codes [11] = '{
    5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b00110,
    5'b01000, 5'b01100, 5'b10000, 5'b11001};

  // Reference model: a run length while hunting, and while locked a list of
  // per-symbol error flags covering the currently open error window.
  bit m_locked = 0;
  int m_run    = 0;
  bit m_win[$];
  int m_errs   = 0;
  int m_idle   = 0;

  function automatic bit code_ok(logic [4:0] s);
    foreach (valid_codes[i]) if (valid_codes[i] == s) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [4:0] rand_valid();
    return valid_codes[$urandom_range(20, 0)];
  endfunction

  function automatic logic [4:0] rand_invalid();
    return invalid_codes[$urandom_range(10, 0)];
  endfunction

  function automatic int model_state();
    if (!m_locked) return (m_run > 0) ? 1 : 0;
    return (m_win.size() == 0) ? 2 : 3;
  endfunction

  function automatic void model_drop();
    m_locked = 0;
    m_run    = 0;
    m_idle   = 0;
    m_win.delete();
  endfunction

  function automatic void model_step(bit rn, bit lc, bit v, logic [4:0] s);
    bit ok;
    int bad;
    if (!rn) begin
      model_drop();
      m_errs = 0;
      return;
    end
    if (lc) begin
      model_drop();
      return;
    end
    if (v) begin
      m_idle = 0;
      ok = code_ok(s);
      if (!ok && m_errs < ERR_SAT) m_errs++;
      if (!m_locked) begin
        if (ok) begin
          m_run++;
          if (m_run >= ACQ) begin
            m_locked = 1;
            m_run    = 0;
          end
        end else begin
          m_run = 0;
        end
      end else if (m_win.size() == 0) begin
        if (!ok) begin
          if (LOSS == 1) model_drop();
          else m_win.push_back(1'b1);
        end
      end else begin
        m_win.push_back(!ok);
        bad = 0;
        foreach (m_win[i]) bad += int'(m_win[i]);
        if (bad >= LOSS) model_drop();
        else if (m_win.size() >= WIN) m_win.delete();
      end
    end else begin
`ifdef RX_STALL_WATCHDOG_EN
      if (model_state() != 0) begin
        m_idle++;
        if (m_idle >= STALL) model_drop();
      end else begin
        m_idle = 0;
      end
`endif
    end
  endfunction

  task automatic step(bit rn, bit lc, bit v, logic [4:0] s);
    exp_t e;
    @(negedge clk);
    #1;
    reset_n      = rn;
    link_control = lc;
    rx_sym_valid = v;
    rx_sym       = s;
    model_step(rn, lc, v, s);
    e.state = model_state();
    e.errs  = m_errs;
    e.phase = phase;
    sb_q.push_back(e);
  endtask

  task automatic sym(logic [4:0] s);
    step(1'b1, 1'b0, 1'b1, s);
  endtask

  task automatic idle(int n);
    repeat (n) step(1'b1, 1'b0, 1'b0, 5'b00000);
  endtask

  task automatic relock();
    step(1'b1, 1'b1, 1'b0, 5'b00000);
    repeat (ACQ) sym(rand_valid());
  endtask

  // Monitor: every clock edge is an observable result; compare on the falling edge.
  initial begin
    exp_t       e;
    logic [1:0] es;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e  = sb_q.pop_front();
        es = 2'(e.state);
        checks++;
        if (sync_state !== es || pcs_status !== (e.state < 2) ||
            loc_rcv_status !== (e.state >= 2) || sym_err_count !== EW'(e.errs)) begin
          errors++;
          $display("FAIL sb phase=%0d got state=%0d pcs=%0b loc=%0b errcnt=%0d, expected state=%0d pcs=%0b loc=%0b errcnt=%0d",
                   e.phase, sync_state, pcs_status, loc_rcv_status, sym_err_count,
                   e.state, (e.state < 2), (e.state >= 2), e.errs);
        end
      end
    end
  end

  initial begin
    bit hpos[31];
    bit vpos[10];
    int n;
    int k;
    int rate;
    bit v;
    bit lc;
    bit rn;

    reset_n      = 1'b0;
    link_control = 1'b0;
    rx_sym_valid = 1'b0;
    rx_sym       = 5'b00000;

    // Reset values, including a strobe held off by reset.
    phase = 0;
    step(1'b0, 1'b0, 1'b0, 5'b00000);
    step(1'b0, 1'b0, 1'b1, 5'b00000);
    step(1'b0, 1'b0, 1'b0, 5'b00000);

    // Acquisition with 64 idle codes.
    phase = 1;
    repeat (ACQ) sym(5'b11111);
    idle(3);

    // Invalid code mid-acquisition restarts the run.
    phase = 2;
    step(1'b1, 1'b1, 1'b0, 5'b00000);
    repeat (40) sym(rand_valid());
    sym(5'b00000);
    repeat (ACQ) sym(rand_valid());

    // Window of 32 with 7 H codes closes back to SYNC_OK.
    phase = 3;
    hpos = '{default: 1'b0};
    hpos[0] = 1'b1;
    n = 0;
    while (n < 6) begin
      k = $urandom_range(30, 1);
      if (!hpos[k]) begin
        hpos[k] = 1'b1;
        n++;
      end
    end
    for (int i = 0; i < 31; i++) sym(hpos[i] ? 5'b00100 : rand_valid());
    sym(rand_valid());

    // 8 invalid codes among 10 symbols loses sync.
    phase = 4;
    vpos = '{default: 1'b0};
    n = 0;
    while (n < 2) begin
      k = $urandom_range(9, 1);
      if (!vpos[k]) begin
        vpos[k] = 1'b1;
        n++;
      end
    end
    for (int i = 0; i < 10; i++) sym(vpos[i] ? rand_valid() : rand_invalid());

    // DISABLE with a simultaneous invalid strobe.
    phase = 5;
    relock();
    step(1'b1, 1'b1, 1'b1, 5'b00100);
    step(1'b1, 1'b0, 1'b0, 5'b00000);

    // Reset in the middle of an error window.
    phase = 6;
    relock();
    sym(5'b00100);
    sym(5'b00000);
    sym(rand_valid());
    step(1'b0, 1'b0, 1'b1, 5'b00100);
    sym(rand_valid());

    // Randomised traffic in blocks of differing error density; saturates the counter.
    phase = 7;
    for (int b = 0; b < 10; b++) begin
      case ($urandom_range(2, 0))
        0:       rate = 1;
        1:       rate = 6;
        default: rate = 30;
      endcase
      for (int c = 0; c < 400; c++) begin
        v  = ($urandom_range(3, 0) != 0);
        lc = ($urandom_range(399, 0) == 0);
        rn = ($urandom_range(1499, 0) != 0);
        step(rn, lc, v, ($urandom_range(99, 0) < rate) ? rand_invalid() : rand_valid());
      end
    end

`ifdef RX_STALL_WATCHDOG_EN
    // Strobe on the terminal cycle keeps lock; a full stall drops it.
    phase = 8;
    relock();
    idle(STALL - 1);
    sym(rand_valid());
    idle(STALL);
    idle(4);
`endif

    phase = 9;
    idle(2);
    repeat (3) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d pending, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mod_147_rx_sync_monitor.md
Name: mod_147_rx_sync_monitor

Overview:
- PCS receive-side code-group sync monitor for the 10BASE-T1S receive path.
- Qualifies incoming 5B code-groups and produces pcs_status and loc_rcv_status, which drive the link monitor state diagram.
- Sits between the PMA receive symbol strobe and the link monitor.
- Registered FSM with acquisition, error-window and saturating error counters.

Parameters:
- ACQ_COUNT, 64: consecutive valid code-groups required to declare sync (range 1 to 255).
- LOSS_COUNT, 8: invalid code-groups within one window that cause loss of sync (range 1 to WINDOW).
- WINDOW, 32: length in symbols of the error-evaluation window (range 1 to 255).
- STALL_CYCLES, 1024: clocks without a symbol strobe before loss of sync. Used only with the optional feature.
- ERR_CNT_W, 16: width of the invalid-symbol counter.

Ports:
- clk  in  1  block clock; symbol rate is no faster than clk.
- reset_n  in  1  synchronous reset, active-low.
- link_control  in  1  0 = ENABLE, 1 = DISABLE.
- rx_sym_valid  in  1  one-clock strobe; rx_sym is sampled on this cycle.
- rx_sym  in  5  received 5B code-group.
- pcs_status  out  1  0 = OK, 1 = NOT_OK.
- loc_rcv_status  out  1  1 = local receiver OK.
- sync_state  out  2  0 = SYNC_LOST, 1 = SYNC_ACQ, 2 = SYNC_OK, 3 = SYNC_ERR.
- sym_err_count  out  ERR_CNT_W  saturating count of invalid code-groups.

Behaviour:
- Clock and reset:
  - Single clock; reset is synchronous and active-low. reset_n is sampled on the rising edge of clk.
  - While reset_n = 0: sync_state = SYNC_LOST, pcs_status = 1 (NOT_OK), loc_rcv_status = 0, all internal counters = 0, sym_err_count = 0.
- DISABLE:
  - While link_control = 1, the block behaves as reset, except sym_err_count holds its value.
  - DISABLE takes priority over any symbol arriving on the same cycle.
- Code-group classification:
  - Valid: the 16 data codes, plus I 11111, J 11000, K 10001, T 01101, R 00111.
  - Invalid: the other 11 values, including H 00100 and 00000.
- Symbol handling:
  - FSM and counters advance only on cycles with rx_sym_valid = 1.
  - All outputs are registered and update on the same rising edge that samples the qualifying symbol.
  - No combinational path from any input to any output.
- SYNC_LOST:
  - Valid symbol: go to SYNC_ACQ, good_cnt = 1. If ACQ_COUNT = 1, go directly to SYNC_OK.
  - Invalid symbol: stay.
- SYNC_ACQ:
  - Valid symbol: good_cnt++. When good_cnt reaches ACQ_COUNT, go to SYNC_OK.
  - Invalid symbol: go to SYNC_LOST, good_cnt = 0.
- SYNC_OK:
  - Invalid symbol: go to SYNC_ERR, err_cnt = 1, win_cnt = 1.
  - If LOSS_COUNT = 1, an invalid symbol goes directly to SYNC_LOST.
- SYNC_ERR:
  - Every symbol: win_cnt++. Invalid symbols also increment err_cnt.
  - err_cnt reaches LOSS_COUNT: go to SYNC_LOST.
  - Otherwise, win_cnt reaches WINDOW: go to SYNC_OK and clear both counters.
  - If both conditions occur on the same symbol, loss wins.
- Status outputs:
  - pcs_status = 0 and loc_rcv_status = 1 exactly when the registered state is SYNC_OK or SYNC_ERR.
  - Both outputs are 1 / 0 respectively in every other state.
- sym_err_count:
  - Increments on every invalid sampled symbol in any state, including SYNC_LOST.
  - Saturates at all-ones and never wraps.
  - Cleared only by reset_n = 0.
- Reset mid-operation, for example in SYNC_ERR with partial counts, fully clears state on the next edge. No counts carry over.
- Counters are sized to hold max(ACQ_COUNT, WINDOW) and must not overflow.

Optional Feature:
- Macro: RX_STALL_WATCHDOG_EN.
- Defined:
  - A stall counter counts clocks with rx_sym_valid = 0 and clears on any strobe.
  - In any state other than SYNC_LOST, reaching STALL_CYCLES forces SYNC_LOST and clears all FSM counters. Status outputs drop on that edge.
  - The stall counter holds at 0 in SYNC_LOST.
  - A strobe on the terminal cycle clears the stall counter and suppresses the stall.
- Undefined:
  - No stall counter is present.
  - State is held indefinitely without strobes.

Test Plan:
- Reset then 64 strobes of I (11111) -> sync_state 1 after the first strobe; state 2, pcs_status 0, loc_rcv_status 1 on the 64th strobe edge; sym_err_count 0.
- In SYNC_ACQ after 40 valid symbols, send 00000 -> state 0, status NOT_OK; 64 further valid symbols are needed to relock; sym_err_count 1.
- Locked, then 31 symbols containing 7 H codes -> state 3 throughout, status stays OK; on the 32nd symbol (valid), state 2 with counters cleared.
- Locked, then 8 invalid codes among the first 10 symbols -> state 0 on the 8th invalid edge; pcs_status 1, loc_rcv_status 0.
- link_control = 1 asserted in SYNC_OK with a simultaneous invalid strobe -> state 0, status NOT_OK, sym_err_count unchanged. reset_n = 0 mid-SYNC_ERR -> all outputs at reset values next edge.
- With RX_STALL_WATCHDOG_EN: locked, strobes stop for 1024 clocks -> state 0 on that edge. Stop for 1023 clocks then strobe -> stays locked.
